// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the universal shift register and its burst controller.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  // Datapath select; encoding matches the manual mode field so idle mode passes straight through.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_RIGHT = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_t;

endpackage

// File: rtl/shift_burst_ctrl.sv
// IDLE/BURST controller: owns the shift count, latched direction and busy/done status,
// and tells the datapath which operation to perform on each edge.
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       dir,
  output sel_t       sel,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(WIDTH + 1);

  burst_state_t   state, state_next;
  logic [CW-1:0]  count, count_next;
  logic           dir_q, dir_next;
  logic           done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      dir_q <= DIR_RIGHT;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      dir_q <= dir_next;
      done  <= done_next;
    end
  end

  // A burst always runs exactly WIDTH shifts; count only decrements while it is at least 1.
  always_comb begin
    state_next = state;
    count_next = count;
    dir_next   = dir_q;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BURST;
          count_next = CW'(WIDTH);
          dir_next   = dir;
        end
      end
      ST_BURST: begin
        count_next = count - CW'(1);
        if (count == CW'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_BURST);
    sel  = sel_t'(mode);
    if (state == ST_BURST) begin
      sel = (dir_q == DIR_LEFT) ? SEL_LEFT : SEL_RIGHT;
    end else if (start) begin
      sel = SEL_LOAD;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold/right/left/load) with an autonomous
// serializer burst driven by shift_burst_ctrl.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             S_in_r,
  input  logic             S_in_l,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] Q,
  output logic             S_out_r,
  output logic             S_out_l,
  output logic             busy,
  output logic             done
);

  sel_t             sel;
  logic [WIDTH-1:0] shr, shl;

  shift_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .start (start),
    .dir   (dir),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  // Built by shift-then-patch so WIDTH=1 needs no special case.
  always_comb begin
    shr            = Q >> 1;
    shr[WIDTH-1]   = S_in_r;
    shl            = Q << 1;
    shl[0]         = S_in_l;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q <= RESET_VALUE;
    end else begin
      case (sel)
        SEL_HOLD:  Q <= Q;
        SEL_RIGHT: Q <= shr;
        SEL_LEFT:  Q <= shl;
        SEL_LOAD:  Q <= D;
        default:   Q <= Q;
      endcase
    end
  end

  assign S_out_r = Q[0];
  assign S_out_l = Q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h00;
  localparam logic [W-1:0] MASK = 8'hFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic [W-1:0] D;
  logic         S_in_r, S_in_l, start, dir;
  logic [W-1:0] Q;
  logic         S_out_r, S_out_l, busy, done;

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  // Reference model state: register value, shifts remaining in the burst, burst direction, done flag.
  logic [W-1:0] m_q;
  int           m_left;
  logic         m_dir;
  logic         m_done;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .D       (D),
    .S_in_r  (S_in_r),
    .S_in_l  (S_in_l),
    .start   (start),
    .dir     (dir),
    .Q       (Q),
    .S_out_r (S_out_r),
    .S_out_l (S_out_l),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shift_right(logic [W-1:0] q, logic sin);
    return (q / 2) | (W'(sin) << (W - 1));
  endfunction

  function automatic logic [W-1:0] shift_left(logic [W-1:0] q, logic sin);
    return ((q * 2) & MASK) | W'(sin);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q <= RV; m_left <= 0; m_dir <= 1'b0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_q    <= m_dir ? shift_left(m_q, S_in_l) : shift_right(m_q, S_in_r);
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
    end else if (start) begin
      m_q <= D; m_dir <= dir; m_left <= W; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (mode)
        2'b01:   m_q <= shift_right(m_q, S_in_r);
        2'b10:   m_q <= shift_left(m_q, S_in_l);
        2'b11:   m_q <= D;
        default: m_q <= m_q;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [W+3:0] act, exp;
      act = {Q, S_out_r, S_out_l, busy, done};
      exp = {m_q, m_q[0], m_q[W-1], (m_left != 0), m_done};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL model_compare t=%0t actual{Q,sr,sl,busy,done}=%h required=%h", $time, act, exp);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rn, input logic [1:0] md, input logic [W-1:0] d,
                               input logic sr, input logic sl, input logic st, input logic dr);
    rst_n = rn; mode = md; D = d; S_in_r = sr; S_in_l = sl; start = st; dir = dr;
    tick();
  endtask

  initial begin
    logic [W-1:0] pat;

    // Reset with start and load requested: reset must win.
    applyStimulus(1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    checking = 1;
    checkOutput("reset_q", 32'(Q), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);

    applyStimulus(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load_a5", 32'(Q), 32'hA5);
    applyStimulus(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("right_sin1", 32'(Q), 32'hD2);
    applyStimulus(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("left_sin0", 32'(Q), 32'hA4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("hold_3", 32'(Q), 32'hA4);

    // Right burst of B4, LSB first.
    pat = 8'b1011_0100;
    applyStimulus(1'b1, 2'b00, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    checkOutput("rburst_c0_q", 32'(Q), 32'hB4);
    for (int j = 0; j < W; j++) begin
      checkOutput($sformatf("rburst_sout_c%0d", j), 32'(S_out_r), 32'(pat[j]));
      checkOutput($sformatf("rburst_busy_c%0d", j), 32'(busy), 32'h1);
      checkOutput($sformatf("rburst_done_c%0d", j), 32'(done), 32'h0);
      tick();
    end
    checkOutput("rburst_end_busy", 32'(busy), 32'h0);
    checkOutput("rburst_end_done", 32'(done), 32'h1);
    checkOutput("rburst_end_q", 32'(Q), 32'h00);
    tick();
    checkOutput("rburst_done_pulse_gone", 32'(done), 32'h0);

    // Left burst of 81 with start/load held high throughout.
    pat = 8'h81;
    applyStimulus(1'b1, 2'b11, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < W; j++) begin
      checkOutput($sformatf("lburst_sout_c%0d", j), 32'(S_out_l), 32'(pat[W-1-j]));
      checkOutput($sformatf("lburst_busy_c%0d", j), 32'(busy), 32'h1);
      tick();
    end
    checkOutput("lburst_end_done", 32'(done), 32'h1);
    checkOutput("lburst_end_busy", 32'(busy), 32'h0);
    checkOutput("lburst_end_q", 32'(Q), 32'hFF);
    tick();
    checkOutput("lburst_restart_busy", 32'(busy), 32'h1);
    checkOutput("lburst_restart_q", 32'(Q), 32'h81);
    checkOutput("lburst_restart_done", 32'(done), 32'h0);

    // Abort the second burst at its cycle 3.
    start = 1'b0;
    tick(); tick(); tick();
    checkOutput("abort_pre_busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_q", 32'(Q), 32'h00);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      checkOutput($sformatf("abort_no_done_%0d", j), 32'(done), 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0), 2'($urandom_range(0, 3)), W'($urandom),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 6) == 0), 1'($urandom));
    end

    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
